// File: rtl/hpdmc_pkg.sv
// Shared constants, state encoding and step record for the HPDMC power-up sequencer.
package hpdmc_pkg;

  localparam logic [3:0] REG_CTRL = 4'h0;
  localparam logic [3:0] REG_CMD  = 4'h4;
  localparam logic [3:0] REG_TIM  = 4'h8;

  // Command nibble: bit0=CS, bit1=WE, bit2=CAS, bit3=RAS, all active-high
  localparam logic [3:0] CMD_PRECHARGE = 4'hB;
  localparam logic [3:0] CMD_AREF      = 4'hD;
  localparam logic [3:0] CMD_LMR       = 4'hF;

  localparam logic [12:0] ADDR_A10      = 13'h400;
  localparam logic [12:0] MR_DLL_RESET  = 13'h100;
  localparam logic [12:0] EMR_DLL_ON    = 13'h000;

  // Control register: bit0=bypass, bit1=sdram reset, bit2=cke
  localparam logic [31:0] CTRL_INIT = 32'h0000_0007;
  localparam logic [31:0] CTRL_RUN  = 32'h0000_0004;

  localparam logic [3:0] LAST_STEP   = 4'd10;
  localparam logic [8:0] BUS_TIMEOUT = 9'd255;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS,
    ST_WAIT,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [3:0]  offset;
    logic [31:0] data;
    logic        we;
    logic [15:0] postwait;
  } step_t;

  function automatic logic [31:0] cmd_word(input logic [1:0]  ba,
                                           input logic [12:0] a,
                                           input logic [3:0]  cmd);
    return {13'd0, ba, a, cmd};
  endfunction

endpackage

// File: rtl/hpdmc_initseq_rom.sv
// Fixed 11-step DDR init program: step index -> {offset, data, we, postwait}.
module hpdmc_initseq_rom
  import hpdmc_pkg::*;
#(
  parameter logic [12:0] MODE           = 13'h033,
  parameter logic [21:0] TIM            = 22'h217212,
  parameter logic [15:0] POWERUP_CYCLES = 16'd20000,
  parameter logic [15:0] DLL_CYCLES     = 16'd200,
  parameter logic [15:0] CMD_GAP        = 16'd8
) (
  input  logic [3:0] i_step,
  output step_t      o_step
);

  always_comb begin
    o_step = '0;
    case (i_step)
      4'd0:  o_step = '{REG_CTRL, CTRL_INIT, 1'b1, POWERUP_CYCLES};
      4'd1:  o_step = '{REG_CMD, cmd_word(2'd0, ADDR_A10, CMD_PRECHARGE), 1'b1, CMD_GAP};
      4'd2:  o_step = '{REG_CMD, cmd_word(2'd1, EMR_DLL_ON, CMD_LMR), 1'b1, CMD_GAP};
      4'd3:  o_step = '{REG_CMD, cmd_word(2'd0, MODE | MR_DLL_RESET, CMD_LMR), 1'b1, DLL_CYCLES};
      4'd4:  o_step = '{REG_CMD, cmd_word(2'd0, ADDR_A10, CMD_PRECHARGE), 1'b1, CMD_GAP};
      4'd5:  o_step = '{REG_CMD, cmd_word(2'd0, 13'd0, CMD_AREF), 1'b1, CMD_GAP};
      4'd6:  o_step = '{REG_CMD, cmd_word(2'd0, 13'd0, CMD_AREF), 1'b1, CMD_GAP};
      4'd7:  o_step = '{REG_CMD, cmd_word(2'd0, MODE, CMD_LMR), 1'b1, CMD_GAP};
      4'd8:  o_step = '{REG_TIM, {10'd0, TIM}, 1'b1, 16'd0};
      4'd9:  o_step = '{REG_TIM, 32'd0, 1'b0, 16'd0};
      4'd10: o_step = '{REG_CTRL, CTRL_RUN, 1'b1, 16'd0};
      default: o_step = '0;
    endcase
  end

endmodule

// File: rtl/hpdmc_initseq.sv
// Wishbone master that walks the HPDMC control slave through DDR power-up init.
module hpdmc_initseq
  import hpdmc_pkg::*;
#(
  parameter logic [31:0] BASE_ADR       = 32'h0,
  parameter logic [12:0] MODE           = 13'h033,
  parameter logic [21:0] TIM            = 22'h217212,
  parameter logic [15:0] POWERUP_CYCLES = 16'd20000,
  parameter logic [15:0] DLL_CYCLES     = 16'd200,
  parameter logic [15:0] CMD_GAP        = 16'd8
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  input  logic        wbm_ack_i
);

  state_t      r_state;
  logic [3:0]  r_step;
  logic [15:0] r_cnt;
  logic [15:0] r_wait_len;
  logic [8:0]  r_to;
  logic        r_busy, r_done, r_error;
  logic        r_cyc, r_stb, r_we;
  logic [31:0] r_adr, r_dat;

  logic        w_launch, w_advance, w_load;
  logic [3:0]  w_load_idx;
  step_t       w_rom;
  logic        w_unused;

  assign w_launch   = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start;
  assign w_advance  = (r_state == ST_WAIT) && (r_cnt == 16'd1) && (r_step != LAST_STEP);
  assign w_load     = w_launch || w_advance;
  // ROM is addressed by the step about to be issued; its postwait is latched at issue time
  assign w_load_idx = w_launch ? 4'd0 : r_step + 4'd1;
  assign w_unused   = ^wbm_dat_i[31:22];

  hpdmc_initseq_rom #(
    .MODE           (MODE),
    .TIM            (TIM),
    .POWERUP_CYCLES (POWERUP_CYCLES),
    .DLL_CYCLES     (DLL_CYCLES),
    .CMD_GAP        (CMD_GAP)
  ) u_rom (
    .i_step (w_load_idx),
    .o_step (w_rom)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= ST_IDLE;
      r_step     <= '0;
      r_cnt      <= '0;
      r_wait_len <= '0;
      r_to       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_cyc      <= 1'b0;
      r_stb      <= 1'b0;
      r_we       <= 1'b0;
      r_adr      <= '0;
      r_dat      <= '0;
    end else if (w_load) begin
      r_state    <= ST_BUS;
      r_step     <= w_load_idx;
      r_busy     <= 1'b1;
      r_cyc      <= 1'b1;
      r_stb      <= 1'b1;
      r_we       <= w_rom.we;
      r_adr      <= BASE_ADR + {28'd0, w_rom.offset};
      r_dat      <= w_rom.data;
      r_wait_len <= (w_rom.postwait == 16'd0) ? 16'd1 : w_rom.postwait;
      r_to       <= '0;
      if (w_launch) begin
        r_done  <= 1'b0;
        r_error <= 1'b0;
      end
    end else begin
      case (r_state)
        ST_BUS: begin
          if (wbm_ack_i) begin
            r_state <= ST_WAIT;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_cnt   <= r_wait_len;
            if (!r_we && (wbm_dat_i[21:0] != TIM))
              r_error <= 1'b1;
          end else if (r_to == BUS_TIMEOUT) begin
            r_state <= ST_DONE;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_error <= 1'b1;
          end else begin
            r_to <= r_to + 9'd1;
          end
        end
        ST_WAIT: begin
          // Non-final expiry is taken by w_advance above
          if (r_cnt == 16'd1) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;
  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = r_dat;
  assign wbm_sel_o = 4'hF;
  assign wbm_cyc_o = r_cyc;
  assign wbm_stb_o = r_stb;
  assign wbm_we_o  = r_we;

endmodule

// File: tb/tb_hpdmc_initseq.sv
// Directed bench: a default-parameter instance and a short-wait instance, each with a registered-ack slave.
module tb_hpdmc_initseq;

  localparam logic [31:0] E_DAT [11] = '{32'h7, 32'h400B, 32'h2000F, 32'h133F, 32'h400B,
                                         32'hD, 32'hD, 32'h33F, 32'h217212, 32'h0, 32'h4};
  localparam logic [31:0] E_ADR [11] = '{32'h0, 32'h4, 32'h4, 32'h4, 32'h4, 32'h4,
                                         32'h4, 32'h4, 32'h8, 32'h8, 32'h0};
  localparam logic        E_WE  [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                         1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

  int vec = 0;
  int miss = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- default-parameter instance ----------------
  logic        d_start = 1'b0;
  logic        d_busy, d_done, d_error, d_cyc, d_stb, d_we;
  logic        d_ack = 1'b0;
  logic [31:0] d_adr, d_dato, d_dati;
  logic [3:0]  d_sel;
  logic [31:0] d_ctrl = '0, d_tim = '0;
  int          d_n = 0;
  logic [31:0] d_ladr [16];
  logic [31:0] d_ldat [16];
  logic        d_lwe  [16];

  hpdmc_initseq u_dut_d (
    .sys_clk (clk), .sys_rst_n (rst_n), .start (d_start),
    .busy (d_busy), .done (d_done), .error (d_error),
    .wbm_adr_o (d_adr), .wbm_dat_o (d_dato), .wbm_dat_i (d_dati), .wbm_sel_o (d_sel),
    .wbm_cyc_o (d_cyc), .wbm_stb_o (d_stb), .wbm_we_o (d_we), .wbm_ack_i (d_ack)
  );

  assign d_dati = (d_adr[3:0] == 4'h8) ? d_tim : d_ctrl;

  always @(posedge clk) begin
    if (d_cyc && d_stb && d_ack) begin
      if (d_n < 16) begin
        d_ladr[d_n] <= d_adr;
        d_ldat[d_n] <= d_dato;
        d_lwe[d_n]  <= d_we;
      end
      d_n <= d_n + 1;
      if (d_we && d_adr[3:0] == 4'h0) d_ctrl <= d_dato;
      if (d_we && d_adr[3:0] == 4'h8) d_tim  <= d_dato;
    end
    d_ack <= d_cyc && d_stb && !d_ack;
  end

  // ---------------- short-wait instance ----------------
  logic        f_start = 1'b0;
  logic        f_busy, f_done, f_error, f_cyc, f_stb, f_we;
  logic        f_ack = 1'b0;
  logic [31:0] f_adr, f_dato, f_dati;
  logic [3:0]  f_sel;
  logic [31:0] f_ctrl = '0, f_tim = '0;
  logic        f_corrupt = 1'b0;
  int          f_stall = -1;
  int          f_n = 0;
  int          f_low = 0;
  logic [31:0] f_ladr [128];
  logic [31:0] f_ldat [128];
  logic        f_lwe  [128];
  int          f_gap  [128];

  hpdmc_initseq #(
    .POWERUP_CYCLES (16'd5),
    .DLL_CYCLES     (16'd1),
    .CMD_GAP        (16'd1)
  ) u_dut_f (
    .sys_clk (clk), .sys_rst_n (rst_n), .start (f_start),
    .busy (f_busy), .done (f_done), .error (f_error),
    .wbm_adr_o (f_adr), .wbm_dat_o (f_dato), .wbm_dat_i (f_dati), .wbm_sel_o (f_sel),
    .wbm_cyc_o (f_cyc), .wbm_stb_o (f_stb), .wbm_we_o (f_we), .wbm_ack_i (f_ack)
  );

  assign f_dati = (f_adr[3:0] == 4'h8) ? (f_tim ^ {31'd0, f_corrupt}) : f_ctrl;

  always @(posedge clk) begin
    if (f_cyc && f_stb && f_ack) begin
      if (f_n < 128) begin
        f_ladr[f_n] <= f_adr;
        f_ldat[f_n] <= f_dato;
        f_lwe[f_n]  <= f_we;
      end
      f_n <= f_n + 1;
      if (f_we && f_adr[3:0] == 4'h0) f_ctrl <= f_dato;
      if (f_we && f_adr[3:0] == 4'h8) f_tim  <= f_dato;
    end
    f_ack <= f_cyc && f_stb && !f_ack && (f_n != f_stall);
    // Gap recorded against the transaction index that is about to be issued
    if (f_stb) begin
      if (f_low > 0 && f_n < 128) f_gap[f_n] <= f_low;
      f_low <= 0;
    end else begin
      f_low <= f_low + 1;
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vec++; if ({f_busy, f_done, f_error} !== 3'b000) begin miss++; $display("FAIL reset_flags: got %b want 000", {f_busy, f_done, f_error}); end
    vec++; if ({f_cyc, f_stb, f_we} !== 3'b000) begin miss++; $display("FAIL reset_bus: got %b want 000", {f_cyc, f_stb, f_we}); end
    vec++; if (f_adr !== 32'h0 || f_dato !== 32'h0) begin miss++; $display("FAIL reset_adr_dat: got %h/%h want 0/0", f_adr, f_dato); end
    vec++; if (f_sel !== 4'hF || d_sel !== 4'hF) begin miss++; $display("FAIL sel: got %h/%h want F/F", f_sel, d_sel); end
    vec++; if ({d_busy, d_done, d_error, d_cyc, d_stb, d_we} !== 6'b0) begin miss++; $display("FAIL reset_default: got %b want 000000", {d_busy, d_done, d_error, d_cyc, d_stb, d_we}); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_defaults;
    int nb;
    nb = 0;
    d_start = 1'b1;
    @(negedge clk);
    d_start = 1'b0;
    for (int i = 0; i < 21000 && !d_done; i++) begin
      if (d_busy) nb++;
      @(negedge clk);
    end
    vec++; if (d_done !== 1'b1) begin miss++; $display("FAIL default_done: got %b want 1", d_done); end
    vec++; if (nb !== 20273) begin miss++; $display("FAIL default_busy_cycles: got %0d want 20273", nb); end
    vec++; if (d_n !== 11) begin miss++; $display("FAIL default_tx_count: got %0d want 11", d_n); end
    for (int k = 0; k < 11; k++) begin
      vec++;
      if (d_ladr[k] !== E_ADR[k] || d_lwe[k] !== E_WE[k] || (E_WE[k] && d_ldat[k] !== E_DAT[k])) begin
        miss++;
        $display("FAIL default_tx%0d: got adr=%h dat=%h we=%b want adr=%h dat=%h we=%b",
                 k, d_ladr[k], d_ldat[k], d_lwe[k], E_ADR[k], E_DAT[k], E_WE[k]);
      end
    end
    vec++; if (d_error !== 1'b0 || d_busy !== 1'b0) begin miss++; $display("FAIL default_flags: got err=%b busy=%b want 0/0", d_error, d_busy); end
    vec++; if (d_ctrl !== 32'h4) begin miss++; $display("FAIL default_ctrl: got %h want 00000004", d_ctrl); end
  endtask

  task automatic test_gaps;
    int base, nb;
    base = f_n;
    nb = 0;
    f_start = 1'b1;
    @(negedge clk);
    f_start = 1'b0;
    vec++; if ({f_busy, f_cyc, f_stb, f_we} !== 4'b1111 || f_adr !== 32'h0) begin miss++; $display("FAIL start_latency: got bcsw=%b adr=%h want 1111 0", {f_busy, f_cyc, f_stb, f_we}, f_adr); end
    for (int i = 0; i < 500 && !f_done; i++) begin
      if (f_busy) nb++;
      @(negedge clk);
    end
    vec++; if (nb !== 37) begin miss++; $display("FAIL fast_busy_cycles: got %0d want 37", nb); end
    vec++; if (f_n - base !== 11) begin miss++; $display("FAIL fast_tx_count: got %0d want 11", f_n - base); end
    for (int k = 0; k < 11; k++) begin
      vec++;
      if (f_ladr[base+k] !== E_ADR[k] || f_lwe[base+k] !== E_WE[k] || (E_WE[k] && f_ldat[base+k] !== E_DAT[k])) begin
        miss++;
        $display("FAIL fast_tx%0d: got adr=%h dat=%h we=%b want adr=%h dat=%h we=%b",
                 k, f_ladr[base+k], f_ldat[base+k], f_lwe[base+k], E_ADR[k], E_DAT[k], E_WE[k]);
      end
    end
    for (int k = 1; k < 11; k++) begin
      vec++;
      if (f_gap[base+k] !== ((k == 1) ? 5 : 1)) begin
        miss++;
        $display("FAIL gap_before_tx%0d: got %0d want %0d", k, f_gap[base+k], (k == 1) ? 5 : 1);
      end
    end
    vec++; if ({f_done, f_error} !== 2'b10 || f_ctrl !== 32'h4) begin miss++; $display("FAIL fast_end: got de=%b ctrl=%h want 10 4", {f_done, f_error}, f_ctrl); end
  endtask

  task automatic test_start_busy;
    int base, nb;
    base = f_n;
    nb = 0;
    f_start = 1'b1;
    @(negedge clk);
    f_start = 1'b0;
    for (int i = 0; i < 500 && !f_done; i++) begin
      if (f_busy) nb++;
      if (i == 3 || i == 15) f_start = 1'b1;
      @(negedge clk);
      f_start = 1'b0;
    end
    vec++; if (nb !== 37) begin miss++; $display("FAIL busy_start_cycles: got %0d want 37", nb); end
    vec++; if (f_n - base !== 11 || f_ldat[base+1] !== 32'h400B) begin miss++; $display("FAIL busy_start_seq: got n=%0d tx1=%h want 11 400B", f_n - base, f_ldat[base+1]); end
  endtask

  task automatic test_corrupt;
    int base;
    base = f_n;
    f_corrupt = 1'b1;
    f_start = 1'b1;
    @(negedge clk);
    f_start = 1'b0;
    for (int i = 0; i < 500 && !f_done; i++) @(negedge clk);
    f_corrupt = 1'b0;
    vec++; if ({f_done, f_error} !== 2'b11) begin miss++; $display("FAIL corrupt_flags: got de=%b want 11", {f_done, f_error}); end
    vec++; if (f_n - base !== 11 || f_ladr[base+10] !== 32'h0 || f_ldat[base+10] !== 32'h4) begin miss++; $display("FAIL corrupt_last: got n=%0d adr=%h dat=%h want 11 0 4", f_n - base, f_ladr[base+10], f_ldat[base+10]); end
  endtask

  task automatic test_done_restart;
    int base;
    base = f_n;
    f_start = 1'b1;
    @(negedge clk);
    f_start = 1'b0;
    vec++; if ({f_busy, f_done, f_error} !== 3'b100) begin miss++; $display("FAIL restart_clear: got bde=%b want 100", {f_busy, f_done, f_error}); end
    for (int i = 0; i < 500 && !f_done; i++) @(negedge clk);
    vec++; if ({f_done, f_error} !== 2'b10 || f_n - base !== 11) begin miss++; $display("FAIL restart_end: got de=%b n=%0d want 10 11", {f_done, f_error}, f_n - base); end
  endtask

  task automatic test_timeout;
    int base, hi;
    base = f_n;
    hi = 0;
    f_stall = base + 2;
    f_start = 1'b1;
    @(negedge clk);
    f_start = 1'b0;
    for (int i = 0; i < 1000 && !f_done; i++) begin
      if (f_n == base + 2 && f_stb) hi++;
      @(negedge clk);
    end
    vec++; if (hi !== 256) begin miss++; $display("FAIL timeout_stb_cycles: got %0d want 256", hi); end
    vec++; if ({f_cyc, f_stb, f_done, f_error} !== 4'b0011) begin miss++; $display("FAIL timeout_state: got csde=%b want 0011", {f_cyc, f_stb, f_done, f_error}); end
    repeat (40) @(negedge clk);
    vec++; if (f_n - base !== 2 || f_cyc !== 1'b0) begin miss++; $display("FAIL timeout_quiet: got n=%0d cyc=%b want 2 0", f_n - base, f_cyc); end
    f_stall = -1;
  endtask

  task automatic test_reset_mid;
    int base, base2;
    base = f_n;
    f_start = 1'b1;
    @(negedge clk);
    f_start = 1'b0;
    for (int i = 0; i < 200 && f_n != base + 4; i++) @(negedge clk);
    vec++; if ({f_busy, f_cyc} !== 2'b10 || f_n - base !== 4) begin miss++; $display("FAIL mid_wait: got bc=%b n=%0d want 10 4", {f_busy, f_cyc}, f_n - base); end
    #1 rst_n = 1'b0;
    #1;
    vec++; if ({f_busy, f_done, f_error, f_cyc, f_stb, f_we} !== 6'b0 || f_adr !== 32'h0 || f_dato !== 32'h0) begin
      miss++; $display("FAIL mid_reset_outputs: got bdecsw=%b adr=%h dat=%h want 0", {f_busy, f_done, f_error, f_cyc, f_stb, f_we}, f_adr, f_dato);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    vec++; if (f_n - base !== 4 || f_busy !== 1'b0 || f_cyc !== 1'b0) begin miss++; $display("FAIL no_resume: got n=%0d busy=%b cyc=%b want 4 0 0", f_n - base, f_busy, f_cyc); end
    base2 = f_n;
    f_start = 1'b1;
    @(negedge clk);
    f_start = 1'b0;
    for (int i = 0; i < 500 && !f_done; i++) @(negedge clk);
    vec++; if (f_n - base2 !== 11 || f_ldat[base2] !== 32'h7 || {f_done, f_error} !== 2'b10) begin
      miss++; $display("FAIL replay: got n=%0d tx0=%h de=%b want 11 7 10", f_n - base2, f_ldat[base2], {f_done, f_error});
    end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_gaps();
    test_start_busy();
    test_corrupt();
    test_done_restart();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
